// File: rtl/tile_mac_accumulator_if.sv
// Tile MAC handshake: start/clear controls, A/B int8 tiles in, status and
// the 4x4 accumulator tile out.
interface tile_mac_accumulator_if #(
    parameter int AccWidth = 32
) ();
    logic                               start_i;
    logic                               clear_i;
    logic                               acc_clr_i;
    logic [0:3][0:3][7:0]               a_tile_i;
    logic [0:3][0:3][7:0]               b_tile_i;
    logic                               busy_o;
    logic                               done_o;
    logic [0:3][0:3][AccWidth-1:0]      acc_o;

    modport master (
        output start_i, clear_i, acc_clr_i, a_tile_i, b_tile_i,
        input  busy_o, done_o, acc_o
    );

    modport slave (
        input  start_i, clear_i, acc_clr_i, a_tile_i, b_tile_i,
        output busy_o, done_o, acc_o
    );
endinterface

// File: rtl/tile_mac_accumulator.sv
// Accumulates the product of two 4x4 int8 tiles into a 4x4 wrapping
// accumulator, one k-slice (16 parallel MACs) per compute cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start_i; acc_clr_i zeroes the accumulator
// COMPUTE | k_q selects the k-slice; four cycles, then done_o pulses
module tile_mac_accumulator #(
    parameter int AccWidth = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    tile_mac_accumulator_if.slave     bus
);

    typedef enum logic {
        IDLE    = 1'b0,
        COMPUTE = 1'b1
    } state_e;

    state_e                         state_q, state_d;
    logic [1:0]                     k_q, k_d;
    logic [0:3][0:3][7:0]           a_q, a_d;
    logic [0:3][0:3][7:0]           b_q, b_d;
    logic                           clear_q, clear_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic [0:3][0:3][AccWidth-1:0]  acc_q, acc_d;

    logic signed [15:0]             prod [4][4];
    logic [0:3][0:3][AccWidth-1:0]  prod_ext;

    // Exact 8x8 signed products, sign-extended before entering the wrapping sum.
    always_comb begin : products
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                prod[i][j]     = $signed(a_q[i][k_q]) * $signed(b_q[k_q][j]);
                prod_ext[i][j] = AccWidth'(prod[i][j]);
            end
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        clear_d = clear_q;
        acc_d   = acc_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    a_d     = bus.a_tile_i;
                    b_d     = bus.b_tile_i;
                    clear_d = bus.clear_i;
                    k_d     = 2'd0;
                    busy_d  = 1'b1;
                    state_d = COMPUTE;
                end else if (bus.acc_clr_i) begin
                    acc_d = '0;
                end
            end
            COMPUTE: begin
                for (int i = 0; i < 4; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        acc_d[i][j] = (k_q == 2'd0 && clear_q) ? prod_ext[i][j]
                                                               : acc_q[i][j] + prod_ext[i][j];
                    end
                end
                k_d = k_q + 2'd1;
                // busy_d/done_d are next-cycle values, so the last slice hands over here.
                if (k_q == 2'd3) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            k_q     <= 2'd0;
            a_q     <= '0;
            b_q     <= '0;
            clear_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            clear_q <= clear_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            acc_q   <= acc_d;
        end
    end

    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.acc_o  = acc_q;

endmodule

// File: tb/tb_tile_mac_accumulator.sv
// Bench for tile_mac_accumulator: 32-bit and 16-bit accumulator instances
// driven identically, checked against a whole-product model plus literals.
module tb_tile_mac_accumulator;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tile_mac_accumulator_if #(.AccWidth(32)) bus32 ();
    tile_mac_accumulator_if #(.AccWidth(16)) bus16 ();

    tile_mac_accumulator #(.AccWidth(32)) dut32 (.clk_i(clk), .rst_ni(rst_n), .bus(bus32));
    tile_mac_accumulator #(.AccWidth(16)) dut16 (.clk_i(clk), .rst_ni(rst_n), .bus(bus16));

    logic st = 1'b0, clr = 1'b0, aclr = 1'b0;
    int   ta [4][4];
    int   tbm[4][4];
    logic [0:3][0:3][7:0] pa, pb;

    always_comb begin
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                pa[i][j] = ta[i][j][7:0];
                pb[i][j] = tbm[i][j][7:0];
            end
    end

    assign bus32.start_i = st;   assign bus16.start_i = st;
    assign bus32.clear_i = clr;  assign bus16.clear_i = clr;
    assign bus32.acc_clr_i = aclr; assign bus16.acc_clr_i = aclr;
    assign bus32.a_tile_i = pa;  assign bus16.a_tile_i = pa;
    assign bus32.b_tile_i = pb;  assign bus16.b_tile_i = pb;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a product is one indivisible event; results appear 5 cycles after start.
    bit [31:0] m_acc32 [4][4];
    bit [15:0] m_acc16 [4][4];
    bit [31:0] r32 [4][4];
    bit [15:0] r16 [4][4];
    int        m_pend = 0;
    bit        m_done = 1'b0;
    int        s;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    m_acc32[i][j] = '0;
                    m_acc16[i][j] = '0;
                end
            m_pend = 0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_pend > 0) begin
                m_pend--;
                if (m_pend == 0) begin
                    m_acc32 = r32;
                    m_acc16 = r16;
                    m_done  = 1'b1;
                end
            end else if (st) begin
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++) begin
                        s = 0;
                        for (int k = 0; k < 4; k++) s += ta[i][k] * tbm[k][j];
                        r32[i][j] = (clr ? 32'd0 : m_acc32[i][j]) + 32'(s);
                        r16[i][j] = (clr ? 16'd0 : m_acc16[i][j]) + 16'(s);
                    end
                m_pend = 4;
            end else if (aclr) begin
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++) begin
                        m_acc32[i][j] = '0;
                        m_acc16[i][j] = '0;
                    end
            end
        end
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [0:3][0:3][31:0] e32;
    logic [0:3][0:3][15:0] e16;

    always @(negedge clk) begin
        chk("busy_vs_model", 512'(bus32.busy_o), 512'(m_pend > 0));
        chk("done_vs_model", 512'(bus32.done_o), 512'(m_done));
        chk("busy16_vs_model", 512'(bus16.busy_o), 512'(m_pend > 0));
        chk("done16_vs_model", 512'(bus16.done_o), 512'(m_done));
        chk("busy_done_exclusive", 512'(bus32.busy_o & bus32.done_o), 512'(0));
        if (m_pend == 0) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    e32[i][j] = m_acc32[i][j];
                    e16[i][j] = m_acc16[i][j];
                end
            chk("acc32_vs_model", 512'(bus32.acc_o), 512'(e32));
            chk("acc16_vs_model", 256'(bus16.acc_o), 256'(e16));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all32(input string name, input int v);
        logic [0:3][0:3][31:0] e;
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) e[i][j] = 32'(v);
        chk(name, 512'(bus32.acc_o), 512'(e));
    endtask

    task automatic chk_all16(input string name, input int v);
        logic [0:3][0:3][15:0] e;
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) e[i][j] = 16'(v);
        chk(name, 256'(bus16.acc_o), 256'(e));
    endtask

    // Expected tile: scale * Bseq[i][j] + colsum_add * (column sum of Bseq) with Bseq = 4i+j+1.
    task automatic chk_bseq(input string name, input int scale, input int colsum_add);
        logic [0:3][0:3][31:0] e;
        int cs [4];
        cs = '{28, 32, 36, 40};
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) e[i][j] = 32'(scale * (4 * i + j + 1) + colsum_add * cs[j]);
        chk(name, 512'(bus32.acc_o), 512'(e));
    endtask

    task automatic load_ident_bseq();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ta[i][j]  = (i == j) ? 1 : 0;
                tbm[i][j] = 4 * i + j + 1;
            end
    endtask

    task automatic load_const(input int av, input int bv);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ta[i][j]  = av;
                tbm[i][j] = bv;
            end
    endtask

    // Start in cycle 0; returns in cycle 5 with busy checked in cycles 1-4 and done in 5.
    task automatic run_product(input string name, input logic c);
        clr = c;
        st  = 1'b1;
        tick();
        st = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            chk({name, "_busy"}, 512'(bus32.busy_o), 512'(1));
            if (n < 4) tick();
        end
        tick();
        chk({name, "_done"}, 512'(bus32.done_o), 512'(1));
        chk({name, "_busy_low"}, 512'(bus32.busy_o), 512'(0));
    endtask

    initial begin
        load_const(0, 0);
        tick();
        tick();
        chk("reset_busy", 512'(bus32.busy_o), 512'(0));
        chk("reset_done", 512'(bus32.done_o), 512'(0));
        chk_all32("reset_acc", 0);
        rst_n = 1'b1;
        tick();

        load_ident_bseq();
        run_product("ident_clear", 1'b1);
        chk_bseq("ident_acc_eq_b", 1, 0);
        tick();
        chk("done_one_cycle", 512'(bus32.done_o), 512'(0));

        run_product("ident_accum", 1'b0);
        chk_bseq("accum_eq_2b", 2, 0);
        tick();
        run_product("ident_reclear", 1'b1);
        chk_bseq("reclear_eq_b", 1, 0);
        tick();
        aclr = 1'b1;
        tick();
        aclr = 1'b0;
        chk_all32("acc_clr_zero", 0);
        tick();

        load_const(-128, -128);
        run_product("neg_sq", 1'b1);
        chk_all32("neg_sq_acc32", 65536);
        chk_all16("neg_sq_acc16_wrap", 0);
        tick();
        load_const(-128, 127);
        run_product("neg_pos", 1'b1);
        chk_all32("neg_pos_acc32", -65024);
        chk_all16("neg_pos_acc16_wrap", 512);
        tick();

        // Inputs scrambled and start re-pulsed mid-product must be ignored.
        load_ident_bseq();
        clr = 1'b1;
        st  = 1'b1;
        tick();
        load_const(5, 7);
        clr = 1'b0;
        for (int n = 1; n <= 3; n++) tick();
        tick();
        st = 1'b0;
        chk("snap_done", 512'(bus32.done_o), 512'(1));
        chk_bseq("snap_acc_eq_b", 1, 0);
        tick();
        chk("snap_no_second_busy", 512'(bus32.busy_o), 512'(0));
        chk("snap_no_second_done", 512'(bus32.done_o), 512'(0));

        // Abort with reset in cycle 2 of a product.
        load_ident_bseq();
        clr = 1'b1;
        st  = 1'b1;
        tick();
        st = 1'b0;
        tick();
        rst_n = 1'b0;
        #2;
        chk("abort_busy", 512'(bus32.busy_o), 512'(0));
        chk_all32("abort_acc", 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            chk("abort_no_done", 512'(bus32.done_o), 512'(0));
        end
        run_product("after_abort", 1'b1);
        chk_bseq("after_abort_eq_b", 1, 0);
        tick();

        // Back-to-back: second start lands in the done cycle of the first.
        load_ident_bseq();
        run_product("b2b_first", 1'b1);
        chk_bseq("b2b_first_eq_b", 1, 0);
        load_const(1, 0);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) tbm[i][j] = 4 * i + j + 1;
        run_product("b2b_second", 1'b0);
        chk_bseq("b2b_sum", 1, 1);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected end of stimulus");
        $fatal(1, "watchdog");
    end

endmodule
